tern_mac_acc13: RTL and testbench
=================================

Name: tern_mac_acc13

Overview:
- Streaming accumulator. Forms sum over i of t[i]*c[i] mod 2^13, where c[i] is a 13-bit mod-q coefficient (q = 8192) and t[i] is a ternary trit in {-1, 0, +1}.
- Sits directly upstream of the 13-bit prefix adder stage and drives it. It instantiates add_2i13_o13 twice:
  - one instance performs two's-complement negation;
  - one instance performs accumulation.
- Used for ternary-by-mod-q inner products in the polynomial multiplier datapath.

Parameters:
- NUM_BIT, 13, coefficient width. The only supported value is 13, fixed by the adder instances.
- MAX_LEN, 701, maximum number of beats per vector. Equals ring degree n.
- CNT_W, 10, beat counter width. Must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_coef  in  13  coefficient c[i].
- in_trit  in  2  trit encoding: 00 = 0, 01 = +1, 11 = -1, 10 = illegal.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  13  accumulated sum mod 2^13.
- out_len  out  CNT_W  number of beats in the vector.
- out_err  out  1  illegal trit seen, or length exceeded MAX_LEN.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; acc, cnt, err, op_reg and last_reg all cleared;
  - out_valid = 0, out_sum = 0, out_len = 0, out_err = 0; in_ready = 0 while in reset;
  - deassertion takes effect at the next clock edge.
- Input handshake: a beat is accepted when in_valid and in_ready are both high at a rising edge.
- Stage 1 (operand select, registered):
  - op_reg is c for trit 01, and ~c + 1 for trit 11;
  - the negation uses an add_2i13_o13 instance with inputs ~c and 13'd1;
  - op_reg is 0 for trit 00 or 10;
  - trit 10 sets err.
- Stage 2: acc <= acc + op_reg through the second add_2i13_o13 instance. Wraps mod 2^13 with no saturation.
- States:
  - IDLE: in_ready = 1, acc = 0, cnt = 0. An accepted beat → ACC; if in_last is also high → DRAIN.
  - ACC: in_ready = 1. Each accepted beat increments cnt. A beat with in_last high → DRAIN.
  - DRAIN: in_ready = 0. Stage 2 consumes the final op_reg → HOLD.
  - HOLD:
    - out_valid = 1, in_ready = 0;
    - out_sum = acc, out_len = cnt, out_err = err, all held stable;
    - when out_ready is high → IDLE, and acc, cnt and err are cleared in the same edge.
- Latency: the last beat is accepted at edge T; out_valid rises after edge T+2. A one-beat vector behaves the same way.
- Throughput: one beat per cycle in IDLE and ACC. Idle cycles (in_valid low) add nothing, and the stage-1 op_reg is zeroed on those cycles.
- cnt saturates at MAX_LEN + 1. Any beat beyond MAX_LEN sets err, but accumulation continues.
- out_ready asserted outside HOLD is ignored.
- in_valid asserted while in_ready is low is ignored; the source must hold the beat.
- Reset asserted mid-vector or in HOLD:
  - immediately clears everything and drops out_valid;
  - no partial result is emitted.
- in_coef is ignored when the trit is 00 or 10.

Test Plan:
- Beats (5, +1), (3, -1), (8191, +1, last), out_ready = 1 → out_sum = 1, out_len = 3, out_err = 0. out_valid rises 2 cycles after the last beat.
- Single beat (1, -1, last) → out_sum = 8191, out_len = 1. Single beat (0, -1, last) → out_sum = 0.
- Beats (100, +1), (7, 10 illegal), (20, -1, last) → out_sum = 80, out_err = 1.
- 702 beats of (1, +1) with in_last on the final beat → out_sum = 702, out_len = 702, out_err = 1. The same test with 701 beats → out_err = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD → out_sum, out_len and out_err stay stable and in_ready stays 0. Then pulse out_ready → next vector (9, +1, last) gives out_sum = 9, showing no carry-over from the previous vector.
- Drop rst_n for one cycle after 3 of 5 beats → out_valid = 0 and outputs = 0. A fresh vector (2, +1), (2, +1, last) then gives out_sum = 4, out_len = 2.

Source files
------------

// File: rtl/tern_mac_acc13.sv
// Ternary-by-mod-q streaming multiply-accumulate.
// Each beat adds +c, -c or 0 to a 13-bit accumulator that wraps mod 2^13.
// The result and the beat count are held until downstream accepts them.

// 13-bit two-input adder; the carry out is dropped, so the sum wraps mod 2^13.
module add_2i13_o13 (
  input  logic [12:0] a,
  input  logic [12:0] b,
  output logic [12:0] s
);

  assign s = a + b;

endmodule

module tern_mac_acc13 #(
  parameter int NUM_BIT = 13,
  parameter int MAX_LEN = 701,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_BIT-1:0] in_coef,
  input  logic [1:0]         in_trit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_BIT-1:0] out_sum,
  output logic [CNT_W-1:0]   out_len,
  output logic               out_err
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] LEN_SAT = CNT_W'(MAX_LEN + 1);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_BIT-1:0] acc;
  logic [NUM_BIT-1:0] acc_sum;
  logic [NUM_BIT-1:0] neg_coef;
  logic [NUM_BIT-1:0] op_sel;
  logic [NUM_BIT-1:0] op_reg;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic               last_reg;
  logic               accept;

  assign in_ready = rst_n & ((state == IDLE) | (state == ACC));
  assign accept   = in_valid & in_ready;

  add_2i13_o13 u_neg (
    .a (~in_coef),
    .b (13'd1),
    .s (neg_coef)
  );

  add_2i13_o13 u_acc (
    .a (acc),
    .b (op_reg),
    .s (acc_sum)
  );

  // Decode the trit into the operand: +c, two's-complement -c, or zero.
  always_comb begin
    op_sel = '0;
    case (in_trit)
      2'b01:   op_sel = in_coef;
      2'b11:   op_sel = neg_coef;
      default: op_sel = '0;
    endcase
  end

  // Stage 1 registers the selected operand; it is zero on every cycle without an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg   <= '0;
      last_reg <= 1'b0;
    end else begin
      op_reg   <= accept ? op_sel : '0;
      last_reg <= accept & in_last;
    end
  end

  // Stage 2 accumulates, counts beats and collects the error flag; it is frozen in HOLD and cleared on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc <= '0;
        cnt <= '0;
        err <= 1'b0;
      end
    end else begin
      acc <= acc_sum;
      if (accept) begin
        if (cnt != LEN_SAT) begin
          cnt <= cnt + 1'b1;
        end
        if ((in_trit == 2'b10) || (cnt >= LEN_MAX)) begin
          err <= 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN stays while last_reg marks the final operand still waiting in stage 1, then moves to HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DRAIN : ACC;
      ACC:     if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (!last_reg) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);
  assign out_sum   = out_valid ? acc : '0;
  assign out_len   = out_valid ? cnt : '0;
  assign out_err   = out_valid & err;

endmodule

// File: tb/tb_tern_mac_acc13.sv
// Directed bench for tern_mac_acc13: each scenario task drives beats and checks results inline.

module tb_tern_mac_acc13;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_coef;
  logic [1:0]  in_trit;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_sum;
  logic [9:0]  out_len;
  logic        out_err;

  int pass_cnt;
  int total_cnt;

  tern_mac_acc13 #(.NUM_BIT(13), .MAX_LEN(701), .CNT_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_trit   (in_trit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_len   (out_len),
    .out_err   (out_err)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_beat(input logic [12:0] coef, input logic [1:0] trit, input logic last);
    in_valid = 1'b1;
    in_coef  = coef;
    in_trit  = trit;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_trit  = 2'b00;
    in_coef  = 13'd0;
  endtask

  task automatic wait_hold(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %0b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== 13'd0 || out_len !== 10'd0 || out_err !== 1'b0)
      $display("[TB] FAIL reset_outputs got sum=%0d len=%0d err=%0b expected 0/0/0", out_sum, out_len, out_err); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL idle_in_ready got %0b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    bit seen;
    send_beat(13'd5, 2'b01, 1'b0);
    send_beat(13'd3, 2'b11, 1'b0);
    send_beat(13'd8191, 2'b01, 1'b1);
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL latency_t1 got %0b expected 0", out_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL latency_t2 got %0b expected 0", out_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL latency_t3 got %0b expected 1", out_valid); else pass_cnt++;
    wait_hold(seen);
    total_cnt++; if (out_sum !== 13'd1) $display("[TB] FAIL basic_sum got %0d expected 1", out_sum); else pass_cnt++;
    total_cnt++; if (out_len !== 10'd3) $display("[TB] FAIL basic_len got %0d expected 3", out_len); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("[TB] FAIL basic_err got %0b expected 0", out_err); else pass_cnt++;
    release_result();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL basic_handoff got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    bit seen;
    send_beat(13'd1, 2'b11, 1'b1);
    wait_hold(seen);
    total_cnt++; if (!seen) $display("[TB] FAIL single_timeout got no out_valid expected out_valid within 20 cycles"); else pass_cnt++;
    total_cnt++; if (out_sum !== 13'd8191) $display("[TB] FAIL single_neg1_sum got %0d expected 8191", out_sum); else pass_cnt++;
    total_cnt++; if (out_len !== 10'd1) $display("[TB] FAIL single_len got %0d expected 1", out_len); else pass_cnt++;
    release_result();
    send_beat(13'd0, 2'b11, 1'b1);
    wait_hold(seen);
    total_cnt++; if (!seen || out_sum !== 13'd0) $display("[TB] FAIL single_neg0_sum got %0d (valid=%0b) expected 0", out_sum, seen); else pass_cnt++;
    release_result();
  endtask

  task automatic test_illegal();
    bit seen;
    send_beat(13'd100, 2'b01, 1'b0);
    send_beat(13'd7, 2'b10, 1'b0);
    send_beat(13'd20, 2'b11, 1'b1);
    wait_hold(seen);
    total_cnt++; if (!seen || out_sum !== 13'd80) $display("[TB] FAIL illegal_sum got %0d (valid=%0b) expected 80", out_sum, seen); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b1) $display("[TB] FAIL illegal_err got %0b expected 1", out_err); else pass_cnt++;
    total_cnt++; if (out_len !== 10'd3) $display("[TB] FAIL illegal_len got %0d expected 3", out_len); else pass_cnt++;
    release_result();
  endtask

  task automatic test_length(input int n, input logic exp_err);
    bit seen;
    for (int i = 0; i < n; i++) begin
      send_beat(13'd1, 2'b01, (i == n - 1));
    end
    wait_hold(seen);
    total_cnt++; if (!seen || out_sum !== 13'(n)) $display("[TB] FAIL len%0d_sum got %0d (valid=%0b) expected %0d", n, out_sum, seen, n); else pass_cnt++;
    total_cnt++; if (out_len !== 10'(n)) $display("[TB] FAIL len%0d_len got %0d expected %0d", n, out_len, n); else pass_cnt++;
    total_cnt++; if (out_err !== exp_err) $display("[TB] FAIL len%0d_err got %0b expected %0b", n, out_err, exp_err); else pass_cnt++;
    release_result();
  endtask

  task automatic test_backpressure();
    bit seen;
    send_beat(13'd5, 2'b01, 1'b0);
    send_beat(13'd6, 2'b01, 1'b1);
    wait_hold(seen);
    total_cnt++; if (!seen) $display("[TB] FAIL bp_timeout got no out_valid expected out_valid within 20 cycles"); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 13'd11 || out_len !== 10'd2 || out_err !== 1'b0)
        $display("[TB] FAIL bp_stable%0d got valid=%0b ready=%0b sum=%0d len=%0d err=%0b expected 1/0/11/2/0",
                 i, out_valid, in_ready, out_sum, out_len, out_err);
      else pass_cnt++;
    end
    release_result();
    send_beat(13'd9, 2'b01, 1'b1);
    wait_hold(seen);
    total_cnt++; if (!seen || out_sum !== 13'd9 || out_len !== 10'd1)
      $display("[TB] FAIL bp_next got sum=%0d len=%0d (valid=%0b) expected 9/1", out_sum, out_len, seen); else pass_cnt++;
    release_result();
  endtask

  task automatic test_reset_mid();
    bit seen;
    send_beat(13'd10, 2'b01, 1'b0);
    send_beat(13'd11, 2'b11, 1'b0);
    send_beat(13'd12, 2'b01, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_sum !== 13'd0 || out_len !== 10'd0 || out_err !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL midreset_outputs got valid=%0b sum=%0d len=%0d err=%0b ready=%0b expected all 0",
               out_valid, out_sum, out_len, out_err, in_ready); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(13'd2, 2'b01, 1'b0);
    send_beat(13'd2, 2'b01, 1'b1);
    wait_hold(seen);
    total_cnt++; if (!seen || out_sum !== 13'd4) $display("[TB] FAIL midreset_sum got %0d (valid=%0b) expected 4", out_sum, seen); else pass_cnt++;
    total_cnt++; if (out_len !== 10'd2) $display("[TB] FAIL midreset_len got %0d expected 2", out_len); else pass_cnt++;
    release_result();
  endtask

  // Scenario sequence and summary.
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_coef   = 13'd0;
    in_trit   = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_single();
    test_illegal();
    test_length(702, 1'b1);
    test_length(701, 1'b0);
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
